// File: rtl/ledpanel_scan_pkg.sv
// Shared types and constants for the LED panel scan controller.
// Also holds the gamma curve used by ledpanel_gamma (LEDPANEL_GAMMA_EN builds).
package ledpanel_scan_pkg;

    typedef enum logic [1:0] {
        SHIFT = 2'd0,
        WAIT  = 2'd1,
        BLANK = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam int SHIFT_LEN = 130;
    localparam int NUM_COLS  = 64;
    localparam int NUM_ROWS  = 8;

    // Square-law curve, rounded up so 0 maps to 0 and 255 maps to 255.
    function automatic logic [7:0] gamma_value(input logic [7:0] x);
        logic [15:0] sq;
        sq = 16'(x) * 16'(x) + 16'd255;
        return sq[15:8];
    endfunction

endpackage

// File: rtl/ledpanel_gamma.sv
// Combinational 8-to-8 gamma table, instantiated by ledpanel_scan only when
// LEDPANEL_GAMMA_EN is defined.
module ledpanel_gamma
    import ledpanel_scan_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] corrected
);

    logic [7:0] lut [256];

    for (genvar gi = 0; gi < 256; gi++) begin : g_lut
        assign lut[gi] = gamma_value(8'(gi));
    end

    assign corrected = lut[value];

endmodule

// File: rtl/ledpanel_scan.sv
// HUB-style LED panel scanner with binary-coded modulation over PLANES bit planes.
// Define LEDPANEL_GAMMA_EN to route pixel data through ledpanel_gamma first.
module ledpanel_scan
    import ledpanel_scan_pkg::*;
#(
    parameter int PLANES = 8,
    parameter int BASE   = 16
) (
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] row,
    output logic [5:0] col,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic       panel_clk,
    output logic       panel_r,
    output logic       panel_g,
    output logic       panel_b,
    output logic       panel_lat,
    output logic       panel_oe_n,
    output logic [2:0] panel_a,
    output logic       frame_start
);

    localparam int ON_MAX  = BASE << (PLANES - 1);
    localparam int ON_W    = $clog2(ON_MAX + 1);
    localparam int PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;

    localparam logic [7:0]         SHIFT_LAST  = 8'(SHIFT_LEN - 1);
    localparam logic [7:0]         CAPTURE_END = 8'(2 * NUM_COLS);
    localparam logic [7:0]         COL_HOLD    = 8'(2 * NUM_COLS - 1);
    localparam logic [2:0]         ROW_LAST    = 3'(NUM_ROWS - 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST  = PLANE_W'(PLANES - 1);
    localparam logic [ON_W-1:0]    ON_BASE     = ON_W'(BASE);

    state_t             state_reg, state_next;
    logic [7:0]         shift_cnt_reg, shift_cnt_next;
    logic [ON_W-1:0]    on_cnt_reg, on_cnt_next;
    logic [2:0]         row_reg, row_next;
    logic [PLANE_W-1:0] plane_reg, plane_next;
    logic [PLANE_W-1:0] shift_plane;
    logic [2:0]         rgb_reg, rgb_next;
    logic               pclk_reg, pclk_next;
    logic               shift_done;
    logic               on_last;
    logic [7:0]         red_g, green_g, blue_g;

`ifdef LEDPANEL_GAMMA_EN
    ledpanel_gamma u_gamma_r (.value(red),   .corrected(red_g));
    ledpanel_gamma u_gamma_g (.value(green), .corrected(green_g));
    ledpanel_gamma u_gamma_b (.value(blue),  .corrected(blue_g));
`else
    assign red_g   = red;
    assign green_g = green;
    assign blue_g  = blue;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= SHIFT;
            shift_cnt_reg <= '0;
            on_cnt_reg    <= '0;
            row_reg       <= ROW_LAST;
            plane_reg     <= PLANE_LAST;
            rgb_reg       <= '0;
            pclk_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shift_cnt_reg <= shift_cnt_next;
            on_cnt_reg    <= on_cnt_next;
            row_reg       <= row_next;
            plane_reg     <= plane_next;
            rgb_reg       <= rgb_next;
            pclk_reg      <= pclk_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        row_next       = row_reg;
        plane_next     = plane_reg;
        rgb_next       = rgb_reg;
        on_cnt_next    = on_cnt_reg;
        shift_cnt_next = '0;

        // While row 7 is on display, the next row shifted in is row 0 of the next plane.
        shift_plane = plane_reg;
        if (row_reg == ROW_LAST)
            shift_plane = (plane_reg == PLANE_LAST) ? '0 : plane_reg + PLANE_W'(1);

        shift_done = (state_reg == SHIFT) && (shift_cnt_reg == SHIFT_LAST);
        // Counter reaches zero at the coming edge (or is already there).
        on_last    = (on_cnt_reg <= ON_W'(1));

        if (state_reg == SHIFT)
            shift_cnt_next = shift_cnt_reg + 8'd1;

        if (state_reg == LATCH)
            on_cnt_next = ON_BASE << plane_reg;
        else if (on_cnt_reg != '0)
            on_cnt_next = on_cnt_reg - ON_W'(1);

        case (state_reg)
            SHIFT: if (shift_done) state_next = on_last ? BLANK : WAIT;
            WAIT:  if (on_last) state_next = BLANK;
            BLANK: begin
                state_next = LATCH;
                row_next   = row_reg + 3'd1;
                plane_next = shift_plane;
            end
            LATCH:   state_next = SHIFT;
            default: state_next = SHIFT;
        endcase

        // Pixel for col c arrives on odd counts 2c+1; shift clock pulses on the
        // following odd count so data is always stable while panel_clk is high.
        if (state_reg == SHIFT && shift_cnt_reg[0] && shift_cnt_reg < CAPTURE_END)
            rgb_next = {red_g[shift_plane], green_g[shift_plane], blue_g[shift_plane]};

        pclk_next = (state_reg == SHIFT) && !shift_cnt_reg[0]
                    && (shift_cnt_reg >= 8'd2) && (shift_cnt_reg <= CAPTURE_END);
    end

    assign col         = (shift_cnt_reg >= COL_HOLD) ? 6'(NUM_COLS - 1) : shift_cnt_reg[6:1];
    assign row         = row_reg;
    assign panel_a     = row_reg;
    assign panel_clk   = pclk_reg;
    assign panel_r     = rgb_reg[2];
    assign panel_g     = rgb_reg[1];
    assign panel_b     = rgb_reg[0];
    assign panel_lat   = (state_reg == LATCH);
    assign panel_oe_n  = !(((state_reg == SHIFT) || (state_reg == WAIT)) && (on_cnt_reg != '0));
    assign frame_start = (state_reg == LATCH) && (row_reg == 3'd0) && (plane_reg == '0);

endmodule

// File: tb/tb_ledpanel_scan.sv
// Self-checking bench for ledpanel_scan: per-slot timing, OE duty, shifted bits,
// frame_start cadence and asynchronous reset mid-shift.
module tb_ledpanel_scan;

    localparam int PLANES = 8;
    localparam int BASE   = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] row;
    logic [5:0] col;
    logic [7:0] red = 8'd0, green = 8'd0, blue = 8'd0;
    logic       panel_clk, panel_r, panel_g, panel_b, panel_lat, panel_oe_n, frame_start;
    logic [2:0] panel_a;

    logic [7:0] fb_r [8][64];
    logic [7:0] fb_g [8][64];
    logic [7:0] fb_b [8][64];

    int pass_cnt = 0;
    int total_cnt = 0;
    int fs_count = 0;

    ledpanel_scan #(.PLANES(PLANES), .BASE(BASE)) dut (
        .clk(clk), .reset(reset), .row(row), .col(col),
        .red(red), .green(green), .blue(blue),
        .panel_clk(panel_clk), .panel_r(panel_r), .panel_g(panel_g), .panel_b(panel_b),
        .panel_lat(panel_lat), .panel_oe_n(panel_oe_n), .panel_a(panel_a),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Framebuffer: registered read of the row being shifted (one below the displayed row).
    always @(posedge clk) begin
        red   <= fb_r[row + 3'd1][col];
        green <= fb_g[row + 3'd1][col];
        blue  <= fb_b[row + 3'd1][col];
    end

    function automatic logic pix_bit(input logic [7:0] v, input int p);
        int g;
`ifdef LEDPANEL_GAMMA_EN
        g = (int'(v) * int'(v) + 255) / 256;
`else
        g = int'(v);
`endif
        return logic'((g >> p) & 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Runs one display slot starting at its first cycle; returns at the first cycle of the next.
    task automatic run_slot(input int sidx, input int dr, input int dp, input bit first);
        int on_exp, len_exp, srow, sp, cyc, oe_cnt, rises, glitch;
        logic prev_clk;
        logic [2:0] prev_rgb, rgb, exp_rgb;
        bit got_lat;
        on_exp  = first ? 0 : (BASE << dp);
        len_exp = ((on_exp > 130) ? on_exp : 130) + 2;
        srow    = (dr + 1) % 8;
        sp      = (dr == 7) ? (dp + 1) % PLANES : dp;
        oe_cnt = 0; rises = 0; glitch = 0; got_lat = 0;
        prev_clk = 1'b0;
        prev_rgb = {panel_r, panel_g, panel_b};
        for (cyc = 0; cyc < 2200; cyc++) begin
            rgb = {panel_r, panel_g, panel_b};
            if (!panel_oe_n) oe_cnt++;
            if (rgb !== prev_rgb && panel_clk) glitch++;
            if (panel_clk && !prev_clk) begin
                if (rises < 64) begin
                    exp_rgb = {pix_bit(fb_r[srow][rises], sp), pix_bit(fb_g[srow][rises], sp),
                               pix_bit(fb_b[srow][rises], sp)};
                    check($sformatf("data s%0d px%0d", sidx, rises), 32'(rgb), 32'(exp_rgb));
                end
                rises++;
            end
            prev_clk = panel_clk;
            prev_rgb = rgb;
            if (panel_lat) begin
                got_lat = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check($sformatf("lat_seen s%0d", sidx), 32'(got_lat), 32'd1);
        check($sformatf("slot_len s%0d", sidx), 32'(cyc + 1), 32'(len_exp));
        check($sformatf("oe_on s%0d", sidx), 32'(oe_cnt), 32'(on_exp));
        check($sformatf("clk_rises s%0d", sidx), 32'(rises), 32'd64);
        check($sformatf("data_glitch s%0d", sidx), 32'(glitch), 32'd0);
        check($sformatf("panel_a s%0d", sidx), 32'(panel_a), 32'(srow));
        check($sformatf("row_eq_a s%0d", sidx), 32'(row), 32'(srow));
        check($sformatf("lat_oe s%0d", sidx), 32'(panel_oe_n), 32'd1);
        check($sformatf("frame_start s%0d", sidx), 32'(frame_start), 32'(srow == 0 && sp == 0));
        if (frame_start) fs_count++;
        $display("slot %0d: disp row %0d plane %0d len %0d oe %0d rises %0d", sidx, dr, dp, cyc + 1, oe_cnt, rises);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " oe_n"}, 32'(panel_oe_n), 32'd1);
        check({tag, " lat"}, 32'(panel_lat), 32'd0);
        check({tag, " pclk"}, 32'(panel_clk), 32'd0);
        check({tag, " rgb"}, 32'({panel_r, panel_g, panel_b}), 32'd0);
        check({tag, " fs"}, 32'(frame_start), 32'd0);
        check({tag, " row"}, 32'(row), 32'd7);
        check({tag, " panel_a"}, 32'(panel_a), 32'd7);
        check({tag, " col"}, 32'(col), 32'd0);
    endtask

    initial begin
        int dr, dp, waited;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 64; c++) begin
                fb_r[r][c] = 8'hA5;
                fb_g[r][c] = 8'($urandom);
                fb_b[r][c] = (c == 0) ? 8'hFF : (c == 63) ? 8'h00 : 8'($urandom);
            end
        end

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;

        // First slot after reset shows nothing; a full frame plus one slot follows.
        dr = 7;
        dp = PLANES - 1;
        for (int s = 0; s < 66; s++) begin
            run_slot(s, dr, dp, s == 0);
            if (dr == 7) dp = (dp + 1) % PLANES;
            dr = (dr + 1) % 8;
        end
        check("frame_start_count", 32'(fs_count), 32'd2);

        // Asynchronous reset in the middle of a shift.
        waited = 0;
        while (col != 6'd30 && waited < 400) begin
            @(posedge clk); #1;
            waited++;
        end
        check("reach_col30", 32'(col), 32'd30);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        check("midreset_hold oe_n", 32'(panel_oe_n), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        run_slot(100, 7, PLANES - 1, 1'b1);
        run_slot(101, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
